// File: rtl/lfs_scheduler_pkg.sv
// Shared definitions for the lfs_scheduler block: default widths, the
// sequencer state type and the parity-feedback next-state function.
package lfs_sched_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } lfs_state_e;

    // One shift step: every bit moves down one place, and the top bit
    // takes the XOR of all bits of the old value.
    function automatic logic [DEF_WIDTH-1:0] lfs_next(input logic [DEF_WIDTH-1:0] q);
        return {^q, q[DEF_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/lfs_scheduler_if.sv
// Requester-side bundle for lfs_scheduler. The master modport is the
// requester view, the slave modport is the scheduler view.
interface lfs_scheduler_if
    import lfs_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [1:0]       req;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic [CNT_W-1:0] steps0;
    logic [CNT_W-1:0] steps1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output req, seed0, seed1, steps0, steps1,
        input  gnt, done, result, busy
    );

    modport slave (
        input  req, seed0, seed1, steps0, steps1,
        output gnt, done, result, busy
    );

endinterface

// File: rtl/lfs_scheduler_rr_arb.sv
// Two-way arbiter for lfs_scheduler. With LFS_SCHED_RR_EN defined a tie
// goes to the requester that did not own the last job; otherwise req[0]
// always wins a tie and last_owner is ignored.
module lfs_rr_arb (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant
);

`ifndef LFS_SCHED_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Pick a one-hot winner among the active requests.
    always_comb begin
        grant = 2'b00;
`ifdef LFS_SCHED_RR_EN
        if (req == 2'b11) begin
            grant = last_owner ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
`else
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/lfs_scheduler.sv
// lfs_scheduler: grants one of two requesters, loads its seed into an
// 8-bit parity-feedback shift register, runs the requested number of
// shifts and returns the final value with a one-cycle done pulse.
// Optional feature macro: LFS_SCHED_RR_EN (round-robin tie breaking).
module lfs_scheduler
    import lfs_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    lfs_scheduler_if.slave       bus
);

    lfs_state_e       state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [1:0]       arb_gnt;
    logic             last_owner;

    lfs_rr_arb u_arb (
        .req        (bus.req),
        .last_owner (last_owner),
        .grant      (arb_gnt)
    );

`ifdef LFS_SCHED_RR_EN
    logic last_q, last_d;

    // Remember which requester won the most recent grant.
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && arb_gnt != 2'b00) begin
            last_d = arb_gnt[1];
        end
    end

    // Last-owner register; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_owner = last_q;
`else
    assign last_owner = 1'b1;
`endif

    // Sequencer next state, datapath and registered output values.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        steps_d  = steps_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        result_d = result_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    seed_d  = arb_gnt[1] ? bus.seed1 : bus.seed0;
                    steps_d = arb_gnt[1] ? bus.steps1 : bus.steps0;
                    gnt_d   = arb_gnt;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                q_d   = seed_q;
                cnt_d = steps_q;
                if (steps_q == '0) begin
                    result_d = seed_q;
                    done_d   = gnt_q;
                    state_d  = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                q_d   = lfs_next(q_q);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = lfs_next(q_q);
                    done_d   = gnt_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            seed_q   <= '0;
            steps_q  <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            result_q <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            steps_q  <= steps_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            result_q <= result_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_lfs_scheduler.sv
// Self-checking bench for lfs_scheduler: directed jobs from the test plan
// followed by randomized jobs, all checked cycle by cycle against a
// job-level reference model.
module tb_lfs_scheduler;

   logic clock;
   logic reset;

   int vectors;
   int miscompares;

   logic [7:0] expResult;
   logic       modelLastOwner;

   lfs_scheduler_if busIf ();

   lfs_scheduler dut (
      .clock (clock),
      .reset (reset),
      .bus   (busIf.slave)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Reference shift: n applications of the parity-feedback rule.
   function automatic logic [7:0] modelShift(input logic [7:0] x, input int n);
      logic [7:0] v;
      logic       p;
      v = x;
      for (int i = 0; i < n; i++) begin
         p = 1'b0;
         for (int b = 0; b < 8; b++) p = p ^ v[b];
         v = (v >> 1) | (8'(p) << 7);
      end
      return v;
   endfunction

   // Which requester the arbitration rules pick for a request pattern.
   function automatic int modelWinner(input logic [1:0] pattern);
      if (pattern == 2'b01) return 0;
      if (pattern == 2'b10) return 1;
`ifdef LFS_SCHED_RR_EN
      return modelLastOwner ? 0 : 1;
`else
      return 0;
`endif
   endfunction

   // Run one job from its request edge to the IDLE cycle after DONE,
   // checking gnt, done, busy and result on every cycle.
   task automatic applyStimulus(input logic [1:0] pattern,
                                input logic [7:0] s0, input logic [7:0] s1,
                                input logic [3:0] n0, input logic [3:0] n1,
                                input int dropCycle, input bit keepReq);
      int         winner;
      int         n;
      logic [1:0] expGnt;
      logic [7:0] finalVal;
      winner   = modelWinner(pattern);
      n        = (winner == 0) ? int'(n0) : int'(n1);
      expGnt   = (winner == 0) ? 2'b01 : 2'b10;
      finalVal = modelShift((winner == 0) ? s0 : s1, n);
      modelLastOwner = (winner == 1);

      busIf.req    = pattern;
      busIf.seed0  = s0;
      busIf.seed1  = s1;
      busIf.steps0 = n0;
      busIf.steps1 = n1;

      for (int c = 1; c <= n + 2; c++) begin
         stepCycle();
         checkOutput("gnt", busIf.gnt, expGnt);
         checkOutput("busy", busIf.busy, 1'b1);
         if (c == n + 2) begin
            checkOutput("done", busIf.done, expGnt);
            expResult = finalVal;
         end else begin
            checkOutput("done_idle", busIf.done, 2'b00);
         end
         checkOutput("result", busIf.result, expResult);
         if (!keepReq && c == dropCycle) busIf.req = 2'b00;
      end
      if (!keepReq) busIf.req = 2'b00;

      stepCycle();
      checkOutput("gnt_after", busIf.gnt, 2'b00);
      checkOutput("busy_after", busIf.busy, 1'b0);
      checkOutput("done_after", busIf.done, 2'b00);
      checkOutput("result_hold", busIf.result, expResult);
   endtask

   initial begin
      logic [1:0] pat;
      logic [7:0] rs0, rs1;
      logic [3:0] rn0, rn1;
      int         wn;
      int         dropAt;

      vectors        = 0;
      miscompares    = 0;
      expResult      = 8'h00;
      modelLastOwner = 1'b1;
      reset          = 1'b1;
      busIf.req      = 2'b00;
      busIf.seed0    = 8'h00;
      busIf.seed1    = 8'h00;
      busIf.steps0   = 4'h0;
      busIf.steps1   = 4'h0;

      stepCycle();
      stepCycle();
      checkOutput("rst_gnt", busIf.gnt, 2'b00);
      checkOutput("rst_done", busIf.done, 2'b00);
      checkOutput("rst_busy", busIf.busy, 1'b0);
      checkOutput("rst_result", busIf.result, 8'h00);
      reset = 1'b0;

      $display("[TB] directed jobs");
      applyStimulus(2'b01, 8'h01, 8'h00, 4'd3, 4'd0, 5, 1'b0);
      checkOutput("tp_seed01_steps3", busIf.result, 8'h60);
      applyStimulus(2'b10, 8'h00, 8'hFF, 4'd0, 4'd1, 3, 1'b0);
      checkOutput("tp_seedFF_steps1", busIf.result, 8'h7F);
      applyStimulus(2'b10, 8'h00, 8'h00, 4'd0, 4'd15, 17, 1'b0);
      checkOutput("tp_seed00_steps15", busIf.result, 8'h00);
      applyStimulus(2'b01, 8'hA5, 8'h00, 4'd0, 4'd0, 2, 1'b0);
      checkOutput("tp_zero_steps", busIf.result, 8'hA5);
      applyStimulus(2'b01, 8'h01, 8'h00, 4'd2, 4'd0, 2, 1'b0);
      checkOutput("tp_drop_req", busIf.result, 8'hC0);

      $display("[TB] both requesters held continuously");
      applyStimulus(2'b11, 8'h3C, 8'hC3, 4'd1, 4'd1, 0, 1'b1);
      applyStimulus(2'b11, 8'h3C, 8'hC3, 4'd1, 4'd1, 0, 1'b1);
      applyStimulus(2'b11, 8'h3C, 8'hC3, 4'd1, 4'd1, 0, 1'b0);

      $display("[TB] reset during shift");
      busIf.req    = 2'b01;
      busIf.seed0  = 8'h5A;
      busIf.steps0 = 4'd10;
      for (int c = 0; c < 5; c++) stepCycle();
      checkOutput("mid_busy", busIf.busy, 1'b1);
      busIf.req = 2'b00;
      reset     = 1'b1;
      stepCycle();
      checkOutput("mid_rst_busy", busIf.busy, 1'b0);
      checkOutput("mid_rst_gnt", busIf.gnt, 2'b00);
      checkOutput("mid_rst_result", busIf.result, 8'h00);
      checkOutput("mid_rst_done", busIf.done, 2'b00);
      reset          = 1'b0;
      expResult      = 8'h00;
      modelLastOwner = 1'b1;
      for (int c = 0; c < 12; c++) begin
         stepCycle();
         checkOutput("lost_job_done", busIf.done, 2'b00);
         checkOutput("lost_job_busy", busIf.busy, 1'b0);
      end
      applyStimulus(2'b01, 8'h01, 8'h00, 4'd3, 4'd0, 5, 1'b0);
      checkOutput("post_rst_job", busIf.result, 8'h60);

      $display("[TB] randomized jobs");
      for (int j = 0; j < 40; j++) begin
         pat    = 2'($urandom_range(1, 3));
         rs0    = 8'($urandom);
         rs1    = 8'($urandom);
         rn0    = 4'($urandom_range(0, 15));
         rn1    = 4'($urandom_range(0, 15));
         wn     = (modelWinner(pat) == 0) ? int'(rn0) : int'(rn1);
         dropAt = $urandom_range(1, wn + 2);
         applyStimulus(pat, rs0, rs1, rn0, rn1, dropAt, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
